// File: rtl/dco_cal_if.sv
// Bus between the DCO calibration sequencer and its surroundings: the
// start request, the DCO edge counter handshake, the loop filter offset and
// the resulting DCO control word with status flags.
//
// Handshake: every request/response here is a single-cycle pulse with no
// back-pressure. start asks for a new search. cnt_req opens one
// measurement window. cnt_valid marks the one cycle in which cnt_val holds
// that window's edge count. A pulse is acted on only in states that expect
// it and is otherwise dropped. No pulse is ever held or replayed.
interface dco_cal_if #(
    parameter int NBIT = 14,
    parameter int CW   = 16
);
    logic                   start;
    logic [CW-1:0]          target_cnt;
    logic                   cnt_req;
    logic                   cnt_valid;
    logic [CW-1:0]          cnt_val;
    logic signed [NBIT:0]   lf_offset;
    logic [NBIT-1:0]        code;
    logic                   busy;
    logic                   done;
    logic                   err;

    // Environment side: loop filter, edge counter, sequencing control
    modport master (
        output start, target_cnt, cnt_valid, cnt_val, lf_offset,
        input  cnt_req, code, busy, done, err
    );

    // Calibration controller side
    modport slave (
        input  start, target_cnt, cnt_valid, cnt_val, lf_offset,
        output cnt_req, code, busy, done, err
    );
endinterface

// File: rtl/dco_cal_ctrl.sv
// Rx DCO control word sequencer. A start pulse runs an MSB-first
// successive-approximation search of the DCO code against a target edge
// count. The result becomes the calibrated code. In TRACK the loop filter
// offset is added to that code, and the sum is saturated to the code range.
module dco_cal_ctrl #(
    parameter int NBIT       = 14,
    parameter int CW         = 16,
    parameter int SETTLE_CYC = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    dco_cal_if.slave   bus,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_TRACK   = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [NBIT-1:0] C_MID     = {1'b1, {(NBIT-1){1'b0}}};
    localparam logic [NBIT-1:0] C_MAX     = {NBIT{1'b1}};
    localparam logic [IW-1:0]   C_TOP_IDX = IW'(NBIT - 1);
    localparam logic [SW-1:0]   C_SET_END = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]   C_TO_END  = TW'(TIMEOUT - 1);

    state_t            r_state;
    logic [NBIT-1:0]   r_code;
    logic [NBIT-1:0]   r_cal_code;
    logic [IW-1:0]     r_idx;
    logic [SW-1:0]     r_settle_cnt;
    logic [TW-1:0]     r_timeout_cnt;
    logic              r_cnt_req;

    state_t            w_state_nxt;
    logic [NBIT-1:0]   w_code_nxt;
    logic [NBIT-1:0]   w_cal_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [SW-1:0]     w_settle_nxt;
    logic [TW-1:0]     w_timeout_nxt;
    logic              w_cnt_req_nxt;

    logic [NBIT-1:0]   w_dec_code;
    logic [IW-1:0]     w_idx_m1;
    logic signed [NBIT+1:0] w_sum;
    logic [NBIT-1:0]   w_track_code;

    // Trial bit decision and saturated tracking sum, both from current registers
    always_comb begin
        w_dec_code = r_code;
        if (bus.cnt_val > bus.target_cnt) begin
            // DCO runs too fast at this trial code; ties keep the bit
            w_dec_code[r_idx] = 1'b0;
        end
        w_idx_m1 = r_idx - IW'(1);

        // Sum is two bits wider than the code, so neither end can wrap
        w_sum = $signed({2'b00, r_cal_code}) + $signed({bus.lf_offset[NBIT], bus.lf_offset});
        if (w_sum[NBIT+1]) begin
            w_track_code = '0;
        end else if (w_sum[NBIT]) begin
            w_track_code = C_MAX;
        end else begin
            w_track_code = w_sum[NBIT-1:0];
        end
    end

    // Next-state and next-register logic of the calibration FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_cal_nxt     = r_cal_code;
        w_idx_nxt     = r_idx;
        w_settle_nxt  = r_settle_cnt;
        w_timeout_nxt = r_timeout_cnt;
        w_cnt_req_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
                    w_state_nxt   = S_SETTLE;
                    w_code_nxt    = C_MID;
                    w_idx_nxt     = C_TOP_IDX;
                    w_settle_nxt  = '0;
                    w_timeout_nxt = '0;
                end
            end
            S_SETTLE: begin
                // Let the DCO settle on the new code, then open one window
                if (r_settle_cnt == C_SET_END) begin
                    w_state_nxt   = S_MEASURE;
                    w_cnt_req_nxt = 1'b1;
                    w_settle_nxt  = '0;
                    w_timeout_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + SW'(1);
                end
            end
            S_MEASURE: begin
                if (bus.cnt_valid) begin
                    if (r_idx != '0) begin
                        w_code_nxt           = w_dec_code;
                        w_code_nxt[w_idx_m1] = 1'b1;
                        w_idx_nxt            = w_idx_m1;
                        w_state_nxt          = S_SETTLE;
                        w_settle_nxt         = '0;
                    end else begin
                        w_code_nxt  = w_dec_code;
                        w_cal_nxt   = w_dec_code;
                        w_state_nxt = S_TRACK;
                    end
                end else if (r_timeout_cnt == C_TO_END) begin
                    // Counter never answered: park the DCO mid-range
                    w_state_nxt   = S_ERR;
                    w_code_nxt    = C_MID;
                    w_timeout_nxt = '0;
                end else begin
                    w_timeout_nxt = r_timeout_cnt + TW'(1);
                end
            end
            S_TRACK: begin
                if (bus.start) begin
                    w_state_nxt   = S_SETTLE;
                    w_code_nxt    = C_MID;
                    w_idx_nxt     = C_TOP_IDX;
                    w_settle_nxt  = '0;
                    w_timeout_nxt = '0;
                end else begin
                    w_code_nxt = w_track_code;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_code_nxt  = C_MID;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_code        <= C_MID;
            r_cal_code    <= C_MID;
            r_idx         <= C_TOP_IDX;
            r_settle_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_cnt_req     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_code        <= w_code_nxt;
            r_cal_code    <= w_cal_nxt;
            r_idx         <= w_idx_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_timeout_cnt <= w_timeout_nxt;
            r_cnt_req     <= w_cnt_req_nxt;
        end
    end

    // Status flags decoded from the registered state
    always_comb begin
        bus.code    = r_code;
        bus.cnt_req = r_cnt_req;
        bus.busy    = (r_state == S_SETTLE) || (r_state == S_MEASURE);
        bus.done    = (r_state == S_TRACK);
        bus.err     = (r_state == S_ERR);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_dco_cal_ctrl.sv
// Directed bench for dco_cal_ctrl. It uses a behavioural edge counter that
// answers each cnt_req after a fixed latency, with a selectable DCO
// frequency model. It checks search results, pulse counts, the timeout,
// TRACK saturation and reset behaviour.
module tb_dco_cal_ctrl;

    localparam int NBIT       = 14;
    localparam int CW         = 16;
    localparam int SETTLE_CYC = 32;
    localparam int TIMEOUT    = 1024;
    localparam int LAT        = 3;
    localparam int BUDGET     = 3000;

    logic clk = 1'b0;
    logic rst_drv = 1'b1;
    logic [2:0] dbg_state;

    logic                  start_drv = 1'b0;
    logic [CW-1:0]         target_drv = '0;
    logic signed [NBIT:0]  lf_drv = '0;
    logic                  resp_valid = 1'b0;
    logic [CW-1:0]         resp_val = '0;

    int model_sel   = 0;
    int withhold_at = 0;
    int req_total   = 0;
    int req_cyc     = 0;
    int cyc         = 0;
    int pend        = 0;
    logic [NBIT-1:0] cap_code = '0;

    int n_pass  = 0;
    int n_total = 0;

    dco_cal_if #(.NBIT(NBIT), .CW(CW)) bus ();

    assign bus.start      = start_drv;
    assign bus.target_cnt = target_drv;
    assign bus.lf_offset  = lf_drv;
    assign bus.cnt_valid  = resp_valid;
    assign bus.cnt_val    = resp_val;

    dco_cal_ctrl #(
        .NBIT(NBIT), .CW(CW), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst_drv),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] dco_model(input int sel, input logic [NBIT-1:0] c);
        logic [CW-1:0] v;
        v = CW'(c);
        case (sel)
            0:       return v >> 2;
            1:       return v + CW'(1);
            default: return v;
        endcase
    endfunction

    // Edge counter: answers each cnt_req LAT cycles later, unless told to withhold
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                resp_valid = 1'b1;
                resp_val   = dco_model(model_sel, cap_code);
            end
        end
        if (bus.cnt_req) begin
            req_total = req_total + 1;
            req_cyc   = cyc;
            if (req_total != withhold_at) begin
                pend     = LAT;
                cap_code = bus.code;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (!(bus.done || bus.err) && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_no_timeout"}, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic run_search(input string tag, input int sel, input logic [CW-1:0] tgt,
                              input logic [NBIT-1:0] exp_code);
        int base;
        model_sel  = sel;
        target_drv = tgt;
        base       = req_total;
        pulse_start();
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_finish(tag);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_code"}, 32'(bus.code), 32'(exp_code));
        check({tag, "_nreq"}, 32'(req_total - base), 32'(NBIT));
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        repeat (3) tick();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_code", 32'(bus.code), 32'h2000);
        check("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
        check("rst_req", 32'(bus.cnt_req), 32'd0);
        rst_drv = 1'b0;
        tick();
        check("idle_hold", 32'(bus.code), 32'h2000);

        // Monotone DCO, cnt = code>>2: largest code with cnt<=0x068A is 0x1A2B
        run_search("sar_shift", 0, 16'h068A, 14'h1A2B);
        tick();
        check("track_hold", 32'(bus.code), 32'h1A2B);

        // Extremes of the search range (restart from TRACK)
        run_search("sar_zero", 1, 16'h0000, 14'h0000);
        run_search("sar_full", 1, 16'hFFFF, 14'h3FFF);

        // TRACK saturation, high side
        run_search("cal_hi", 2, 16'h3FF0, 14'h3FF0);
        lf_drv = 15'sd100;
        tick();
        check("clamp_hi", 32'(bus.code), 32'h3FFF);
        lf_drv = 15'sd0;

        // TRACK saturation, low side; zero and small offsets
        run_search("cal_lo", 2, 16'h0010, 14'h0010);
        lf_drv = -15'sd100;
        tick();
        check("clamp_lo", 32'(bus.code), 32'h0000);
        lf_drv = 15'sd0;
        tick();
        check("offset_zero", 32'(bus.code), 32'h0010);
        lf_drv = 15'sd5;
        tick();
        check("offset_pos", 32'(bus.code), 32'h0015);
        lf_drv = -15'sd3;
        tick();
        check("offset_neg", 32'(bus.code), 32'h000D);
        lf_drv = 15'sd0;

        // Timeout: third measurement never answered
        model_sel   = 0;
        target_drv  = 16'h068A;
        base        = req_total;
        withhold_at = base + 3;
        pulse_start();
        wait_finish("tmo");
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_latency", 32'(cyc - req_cyc), 32'(TIMEOUT));
        check("tmo_busy", 32'(bus.busy), 32'd0);
        check("tmo_code", 32'(bus.code), 32'h2000);
        check("tmo_nreq", 32'(req_total - base), 32'd3);
        tick();
        check("err_hold", 32'(bus.err), 32'd1);
        withhold_at = 0;
        run_search("after_err", 0, 16'h068A, 14'h1A2B);
        check("after_err_clear", 32'(bus.err), 32'd0);

        // start inside SETTLE is ignored: search still issues exactly NBIT requests
        base = req_total;
        pulse_start();
        n = 0;
        while (!((req_total - base) >= 3 && dbg_state == 3'd1) && n < BUDGET) begin
            tick();
            n++;
        end
        check("mid_settle_seen", 32'(n < BUDGET), 32'd1);
        pulse_start();
        check("mid_settle_state", 32'(dbg_state), 32'd1);
        wait_finish("mid_start");
        check("mid_start_code", 32'(bus.code), 32'h1A2B);
        check("mid_start_nreq", 32'(req_total - base), 32'(NBIT));

        // Reset during MEASURE after five decided bits
        base = req_total;
        pulse_start();
        n = 0;
        while ((req_total - base) < 6 && n < BUDGET) begin
            tick();
            n++;
        end
        check("rst6_seen", 32'(n < BUDGET), 32'd1);
        check("rst6_in_measure", 32'(dbg_state), 32'd2);
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        check("rst6_state", 32'(dbg_state), 32'd0);
        check("rst6_code", 32'(bus.code), 32'h2000);
        check("rst6_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
        repeat (3) tick();
        check("late_valid_state", 32'(dbg_state), 32'd0);
        check("late_valid_code", 32'(bus.code), 32'h2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
